// File: rtl/tq_recon_4x4.sv
// tq_recon_4x4 -- luma 4x4 reconstruction stage.
//
// This block takes one 4x4 block of residuals and the matching 4x4 block of
// prediction pixels. It adds each residual to its prediction pixel and clips
// the result to 0..255. It then streams the reconstructed block out one row
// per cycle. Each row also carries its write address in the 16x16 macroblock
// buffer, and the blocks follow the H.264 luma 4x4 scan order.
//
// Ports
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   res_iRC  [14:0]           residual, two's complement, row R / column C
//   pred_iRC [7:0]            unsigned prediction pixel, same layout
//   res_valid_i / res_ready_o block handshake
//   rec_data_o [31:0]         reconstructed row, column 0 in [7:0]
//   rec_addr_o [5:0]          buffer row address {y[3:0], x4[1:0]}
//   rec_valid_o / rec_ready_i row handshake
//   mb_done_o                 one-cycle pulse after block 15 row 3 is taken
module tq_recon_4x4 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [14:0] res_i00, res_i01, res_i02, res_i03,
  input  logic [14:0] res_i10, res_i11, res_i12, res_i13,
  input  logic [14:0] res_i20, res_i21, res_i22, res_i23,
  input  logic [14:0] res_i30, res_i31, res_i32, res_i33,
  input  logic [7:0]  pred_i00, pred_i01, pred_i02, pred_i03,
  input  logic [7:0]  pred_i10, pred_i11, pred_i12, pred_i13,
  input  logic [7:0]  pred_i20, pred_i21, pred_i22, pred_i23,
  input  logic [7:0]  pred_i30, pred_i31, pred_i32, pred_i33,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  output logic [31:0] rec_data_o,
  output logic [5:0]  rec_addr_o,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic        mb_done_o
);

  typedef enum logic {S_IDLE, S_OUT} state_t;

  state_t       state_q, state_d;
  logic [1:0]   row_q;
  logic [3:0]   blk_cnt_q;
  logic         mb_done_q;
  logic [127:0] blk_q;
  logic [127:0] clip_w;
  logic [14:0]  res_a  [16];
  logic [7:0]   pred_a [16];
  logic         blk_accept;
  logic         row_accept;

  // Flatten the ports into row-major arrays: index = row*4 + column.
  assign res_a[0]  = res_i00;  assign res_a[1]  = res_i01;
  assign res_a[2]  = res_i02;  assign res_a[3]  = res_i03;
  assign res_a[4]  = res_i10;  assign res_a[5]  = res_i11;
  assign res_a[6]  = res_i12;  assign res_a[7]  = res_i13;
  assign res_a[8]  = res_i20;  assign res_a[9]  = res_i21;
  assign res_a[10] = res_i22;  assign res_a[11] = res_i23;
  assign res_a[12] = res_i30;  assign res_a[13] = res_i31;
  assign res_a[14] = res_i32;  assign res_a[15] = res_i33;

  assign pred_a[0]  = pred_i00; assign pred_a[1]  = pred_i01;
  assign pred_a[2]  = pred_i02; assign pred_a[3]  = pred_i03;
  assign pred_a[4]  = pred_i10; assign pred_a[5]  = pred_i11;
  assign pred_a[6]  = pred_i12; assign pred_a[7]  = pred_i13;
  assign pred_a[8]  = pred_i20; assign pred_a[9]  = pred_i21;
  assign pred_a[10] = pred_i22; assign pred_a[11] = pred_i23;
  assign pred_a[12] = pred_i30; assign pred_a[13] = pred_i31;
  assign pred_a[14] = pred_i32; assign pred_a[15] = pred_i33;

  // The 16-bit sum spans -16384..16638, so it cannot overflow. Bit 15 is the
  // sign. Any set bit in [14:8] of a positive sum means the sum exceeds 255.
  function automatic logic [7:0] clip_pix(input logic [14:0] res,
                                          input logic [7:0]  pred);
    logic [15:0] sum;
    sum = {res[14], res} + {8'h00, pred};
    if (sum[15])       return 8'h00;
    else if (|sum[14:8]) return 8'hFF;
    else               return sum[7:0];
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_clip
    assign clip_w[i*8 +: 8] = clip_pix(res_a[i], pred_a[i]);
  end

  // NOTE: each signal written in always_comb gets a default first. Without
  // the defaults, a path that skips an assignment infers a latch.
  always_comb begin
    state_d     = state_q;
    res_ready_o = 1'b0;
    rec_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        res_ready_o = 1'b1;
        if (res_valid_i) state_d = S_OUT;
      end
      S_OUT: begin
        rec_valid_o = 1'b1;
        // A new block may enter on the same edge that retires the last row.
        res_ready_o = (row_q == 2'd3) && rec_ready_i;
        if (rec_ready_i && (row_q == 2'd3) && !res_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign blk_accept = res_valid_i && res_ready_o;
  assign row_accept = rec_valid_o && rec_ready_i;

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever order the processes run in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q     <= 2'd0;
      blk_cnt_q <= 4'd0;
      mb_done_q <= 1'b0;
    end else begin
      mb_done_q <= row_accept && (row_q == 2'd3) && (blk_cnt_q == 4'd15);
      if (blk_accept)      row_q <= 2'd0;
      else if (row_accept) row_q <= row_q + 2'd1;
      if (row_accept && (row_q == 2'd3)) blk_cnt_q <= blk_cnt_q + 4'd1;
    end
  end

  // NOTE: the pixel store has no reset. It is only read while rec_valid_o is
  // high, and every entry into S_OUT loads it first.
  always_ff @(posedge clk_i) begin
    if (blk_accept) blk_q <= clip_w;
  end

  assign rec_data_o = rec_valid_o ? blk_q[{row_q, 5'd0} +: 32] : 32'd0;
  assign rec_addr_o = {blk_cnt_q[3], blk_cnt_q[1], row_q, blk_cnt_q[2], blk_cnt_q[0]};
  assign mb_done_o  = mb_done_q;

endmodule
